tree_serializer_feeder: RTL and testbench
=========================================

// Module: tree_serializer_feeder
// PURPOSE
//   Upstream stage of the tree serializer. Accepts parallel words over a valid/ready
//   handshake and buffers them in a small FIFO. Presents one word on PAR_OUT, held
//   stable for exactly FRAME_CYCLES clocks, so the serializer's PAR_IN never changes
//   mid-frame. Substitutes IDLE_PATTERN on underrun.
// PARAMETERS
//   INPUTS_NUM    8      word width; equals the serializer's INPUTS_NUM (power of 2, >=2)
//   DEPTH         4      FIFO entries (power of 2, >=2)
//   FRAME_CYCLES  8      CLK cycles per serialized word (>=2)
//   IDLE_PATTERN  'hA5   word driven on PAR_OUT when no data is available (INPUTS_NUM bits)
// PORTS
//   CLK          in   1                  serializer root clock; all state on posedge
//   RESET_N      in   1                  asynchronous active-low reset
//   ENABLE       in   1                  1 = frame counter runs; 0 = halt and drive idle
//   IN_DATA      in   INPUTS_NUM         word to enqueue
//   IN_VALID     in   1                  IN_DATA valid
//   IN_READY     out  1                  FIFO can accept; = !full (registered state, no path from pop)
//   PAR_OUT      out  INPUTS_NUM         word to serializer PAR_IN, registered
//   FRAME_START  out  1                  1-cycle pulse in the cycle a new PAR_OUT word appears
//   UNDERRUN     out  1                  1-cycle pulse when a load found the FIFO empty
//   LEVEL        out  $clog2(DEPTH)+1    current FIFO occupancy
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - FIFO empty, slot counter 0, PAR_OUT=IDLE_PATTERN, FRAME_START=0, UNDERRUN=0.
//   - LEVEL=0, IN_READY=1.
//   Push: rising edge with IN_VALID && IN_READY writes IN_DATA at wr_ptr. wr_ptr wraps mod DEPTH.
//   Slot counter: while ENABLE=1, counts 0..FRAME_CYCLES-1 and wraps to 0.
//   ENABLE=0:
//   - counter forced to 0; PAR_OUT <= IDLE_PATTERN on next edge.
//   - no pops; FRAME_START=0, UNDERRUN=0. Pushes still accepted.
//   Load event = rising edge with ENABLE=1 && slot==0:
//   - FIFO non-empty: PAR_OUT <= head word, rd_ptr++, FRAME_START <= 1.
//   - FIFO empty: PAR_OUT <= IDLE_PATTERN, FRAME_START <= 1, UNDERRUN <= 1.
//   - First load after ENABLE rises happens on the first enabled edge.
//   - PAR_OUT holds between load events: exactly FRAME_CYCLES cycles per word.
//   Latency: word pushed into an empty FIFO at edge t is eligible for a load at edge t+1 or later.
//   Simultaneous push+pop: both take effect; LEVEL unchanged. When full, IN_READY=0 and the push is
//     ignored even if a pop occurs in the same cycle; IN_READY rises the following cycle.
//   Full/empty: pointers carry one extra wrap bit; full = MSBs differ and indices equal.
//   Mid-frame RESET_N assertion: all state returns to reset values immediately; FIFO contents discarded.
//   IN_DATA is sampled only on accepted pushes; X on IN_DATA while IN_VALID=0 must not propagate.
// CONFIGURATION
//   TREE_SER_FEEDER_UNDERRUN_CNT_EN
//   - defined: adds output UNDERRUN_CNT [15:0], reset 0. Increments on each UNDERRUN pulse,
//     saturates at 16'hFFFF, cleared only by reset.
//   - undefined: port and counter absent; all other behaviour identical.
// TESTING
//   (INPUTS_NUM=8, DEPTH=4, FRAME_CYCLES=8, IDLE_PATTERN=8'hA5)
//   1. Reset, ENABLE=1, no pushes
//      -> PAR_OUT=A5 throughout; FRAME_START and UNDERRUN pulse every 8 cycles; LEVEL=0.
//   2. Push 11,22,33 back-to-back with ENABLE=0, then ENABLE=1
//      -> PAR_OUT=11,22,33 for 8 cycles each, then A5 with UNDERRUN; LEVEL 3->2->1->0.
//   3. Push 5 words with ENABLE=0
//      -> IN_READY=0 after 4th accept; 5th held off; LEVEL=4; after first load IN_READY=1 next cycle.
//   4. Push exactly in the cycle of a load with LEVEL=2
//      -> LEVEL stays 2; pushed word appears in order two frames later.
//   5. Assert RESET_N low at slot 3 with LEVEL=3
//      -> PAR_OUT=A5, LEVEL=0, IN_READY=1 immediately; after release, UNDERRUN on first load.
//   6. With macro defined: 3 empty frames -> UNDERRUN_CNT=3; force 16'hFFFF -> stays 16'hFFFF.

Source files
------------

// File: rtl/tree_serializer_feeder.sv
// Feeder for the tree serializer: a small FIFO that hands one word to PAR_OUT per frame.
// Optional underrun counter output is enabled by defining TREE_SER_FEEDER_UNDERRUN_CNT_EN.
module tree_serializer_feeder #(
    parameter int                    INPUTS_NUM   = 8,
    parameter int                    DEPTH        = 4,
    parameter int                    FRAME_CYCLES = 8,
    parameter logic [INPUTS_NUM-1:0] IDLE_PATTERN = 'hA5
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       ENABLE,
    input  logic [INPUTS_NUM-1:0]      IN_DATA,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    output logic [INPUTS_NUM-1:0]      PAR_OUT,
    output logic                       FRAME_START,
    output logic                       UNDERRUN,
`ifdef TREE_SER_FEEDER_UNDERRUN_CNT_EN
    output logic [15:0]                UNDERRUN_CNT,
`endif
    output logic [$clog2(DEPTH):0]     LEVEL
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(FRAME_CYCLES - 1);

    // Handshake: a word transfers on a rising edge where IN_VALID && IN_READY.
    // IN_READY depends only on registered pointers, never on this cycle's pop.

    logic [INPUTS_NUM-1:0] mem_q [DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [INPUTS_NUM-1:0] par_out_q, par_out_d;
    logic                  frame_start_q, frame_start_d;
    logic                  underrun_q, underrun_d;

    logic full, empty, push, load, pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = IN_VALID && !full;
    assign load  = ENABLE && (slot_q == '0);
    assign pop   = load && !empty;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        slot_d        = slot_q;
        par_out_d     = par_out_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        if (!ENABLE) begin
            slot_d    = '0;
            par_out_d = IDLE_PATTERN;
        end else begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
            if (load) begin
                frame_start_d = 1'b1;
                underrun_d    = empty;
                par_out_d     = empty ? IDLE_PATTERN : mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            slot_q        <= '0;
            par_out_q     <= IDLE_PATTERN;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            slot_q        <= slot_d;
            par_out_q     <= par_out_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    // Storage needs no reset: the pointers alone decide which entries are live.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= IN_DATA;
    end

`ifdef TREE_SER_FEEDER_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            underrun_cnt_q <= '0;
        else if (underrun_d && (underrun_cnt_q != 16'hFFFF))
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end

    assign UNDERRUN_CNT = underrun_cnt_q;
`endif

    assign IN_READY    = !full;
    assign PAR_OUT     = par_out_q;
    assign FRAME_START = frame_start_q;
    assign UNDERRUN    = underrun_q;
    assign LEVEL       = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_tree_serializer_feeder.sv
// Directed bench for tree_serializer_feeder (INPUTS_NUM=8, DEPTH=4, FRAME_CYCLES=8, idle A5).
module tb_tree_serializer_feeder;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] par_out;
  logic       frame_start;
  logic       underrun;
  logic [2:0] level;
`ifdef TREE_SER_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [7:0] exp_q[$];

  tree_serializer_feeder #(
    .INPUTS_NUM(8), .DEPTH(4), .FRAME_CYCLES(8), .IDLE_PATTERN(8'hA5)
  ) dut (
    .CLK(clk), .RESET_N(rst_n), .ENABLE(enable),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .PAR_OUT(par_out), .FRAME_START(frame_start), .UNDERRUN(underrun),
`ifdef TREE_SER_FEEDER_UNDERRUN_CNT_EN
    .UNDERRUN_CNT(underrun_cnt),
`endif
    .LEVEL(level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_data  = 'x;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_word(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++; if (par_out !== 8'hA5) $display("FAIL reset_par got %h exp a5", par_out); else pass_cnt++;
    chk_cnt++; if (level !== 3'd0) $display("FAIL reset_level got %0d exp 0", level); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", in_ready); else pass_cnt++;
    chk_cnt++; if ({frame_start, underrun} !== 2'b00) $display("FAIL reset_pulses got %b exp 00", {frame_start, underrun}); else pass_cnt++;
  endtask

  task automatic test_idle_underrun();
    logic fs_exp;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      fs_exp = (i % 8 == 0);
      chk_cnt++; if (frame_start !== fs_exp) $display("FAIL idle_fs cyc %0d got %b exp %b", i, frame_start, fs_exp); else pass_cnt++;
      chk_cnt++; if (underrun !== fs_exp) $display("FAIL idle_ur cyc %0d got %b exp %b", i, underrun, fs_exp); else pass_cnt++;
      chk_cnt++; if (par_out !== 8'hA5 || level !== 3'd0) $display("FAIL idle_out cyc %0d got %h/%0d exp a5/0", i, par_out, level); else pass_cnt++;
    end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_cnt++; if ({frame_start, underrun} !== 2'b00) $display("FAIL disabled_pulses cyc %0d got %b exp 00", i, {frame_start, underrun}); else pass_cnt++;
    end
  endtask

  task automatic test_ordered_frames();
    logic [7:0] words [4];
    logic [2:0] levels [4];
    logic       fs_exp;
    int         f;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'hA5;
    levels[0] = 3'd2; levels[1] = 3'd1; levels[2] = 3'd0; levels[3] = 3'd0;
    do_reset();
    in_valid = 1'b1;
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33; tick();
    in_valid = 1'b0; in_data = 'x;
    chk_cnt++; if (level !== 3'd3) $display("FAIL order_prelevel got %0d exp 3", level); else pass_cnt++;
    chk_cnt++; if (par_out !== 8'hA5) $display("FAIL order_preidle got %h exp a5", par_out); else pass_cnt++;
    enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      f = i / 8;
      fs_exp = (i % 8 == 0);
      chk_cnt++; if (par_out !== words[f]) $display("FAIL order_par cyc %0d got %h exp %h", i, par_out, words[f]); else pass_cnt++;
      chk_cnt++; if (level !== levels[f]) $display("FAIL order_level cyc %0d got %0d exp %0d", i, level, levels[f]); else pass_cnt++;
      chk_cnt++; if (frame_start !== fs_exp) $display("FAIL order_fs cyc %0d got %b exp %b", i, frame_start, fs_exp); else pass_cnt++;
      chk_cnt++; if (underrun !== (fs_exp && f == 3)) $display("FAIL order_ur cyc %0d got %b exp %b", i, underrun, fs_exp && f == 3); else pass_cnt++;
    end
  endtask

  task automatic test_full();
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL full_ready_pre k %0d got %b exp 1", k, in_ready); else pass_cnt++;
      in_valid = 1'b1;
      in_data  = 8'(k + 1);
      exp_q.push_back(8'(k + 1));
      tick();
    end
    in_data = 8'h05;
    tick();
    tick();
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL full_ready got %b exp 0", in_ready); else pass_cnt++;
    chk_cnt++; if (level !== 3'd4) $display("FAIL full_level got %0d exp 4", level); else pass_cnt++;
    enable = 1'b1;
    tick();
    chk_cnt++; if (par_out !== exp_q.pop_front()) $display("FAIL full_first got %h exp 01", par_out); else pass_cnt++;
    chk_cnt++; if (level !== 3'd3) $display("FAIL full_nopush got %0d exp 3", level); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL full_ready_rise got %b exp 1", in_ready); else pass_cnt++;
    exp_q.push_back(8'h05);
    tick();
    in_valid = 1'b0; in_data = 'x;
    chk_cnt++; if (level !== 3'd4 || in_ready !== 1'b0) $display("FAIL full_refill got %0d/%b exp 4/0", level, in_ready); else pass_cnt++;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (frame_start === 1'b1 && exp_q.size() > 0) begin
        chk_cnt++; if (par_out !== exp_q[0]) $display("FAIL full_order got %h exp %h", par_out, exp_q[0]); else pass_cnt++;
        void'(exp_q.pop_front());
      end
    end
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL full_drain got %0d left exp 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_push_on_load();
    do_reset();
    exp_q.delete();
    push_word(8'hAA);
    push_word(8'hBB);
    exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'hCC);
    enable   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hCC;
    tick();
    in_valid = 1'b0; in_data = 'x;
    chk_cnt++; if (level !== 3'd2) $display("FAIL pushload_level got %0d exp 2", level); else pass_cnt++;
    chk_cnt++; if (par_out !== exp_q[0]) $display("FAIL pushload_first got %h exp %h", par_out, exp_q[0]); else pass_cnt++;
    void'(exp_q.pop_front());
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 7 || i == 15) begin
        chk_cnt++; if (frame_start !== 1'b1 || par_out !== exp_q[0]) $display("FAIL pushload_order cyc %0d got %b/%h exp 1/%h", i, frame_start, par_out, exp_q[0]); else pass_cnt++;
        void'(exp_q.pop_front());
      end
    end
    chk_cnt++; if (level !== 3'd0) $display("FAIL pushload_end got %0d exp 0", level); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    push_word(8'h41);
    push_word(8'h42);
    push_word(8'h43);
    push_word(8'h44);
    enable = 1'b1;
    tick();
    tick();
    tick();
    chk_cnt++; if (level !== 3'd3 || par_out !== 8'h41) $display("FAIL midrst_pre got %0d/%h exp 3/41", level, par_out); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (par_out !== 8'hA5) $display("FAIL midrst_par got %h exp a5", par_out); else pass_cnt++;
    chk_cnt++; if (level !== 3'd0 || in_ready !== 1'b1) $display("FAIL midrst_fifo got %0d/%b exp 0/1", level, in_ready); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    chk_cnt++; if ({frame_start, underrun} !== 2'b11 || par_out !== 8'hA5) $display("FAIL midrst_first got %b/%h exp 11/a5", {frame_start, underrun}, par_out); else pass_cnt++;
    enable = 1'b0;
  endtask

`ifdef TREE_SER_FEEDER_UNDERRUN_CNT_EN
  task automatic test_underrun_cnt();
    do_reset();
    chk_cnt++; if (underrun_cnt !== 16'd0) $display("FAIL cnt_reset got %0d exp 0", underrun_cnt); else pass_cnt++;
    enable = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk_cnt++; if (underrun_cnt !== 16'd3) $display("FAIL cnt_three got %0d exp 3", underrun_cnt); else pass_cnt++;
    force dut.underrun_cnt_q = 16'hFFFF;
    tick();
    release dut.underrun_cnt_q;
    for (int i = 0; i < 16; i++) tick();
    chk_cnt++; if (underrun_cnt !== 16'hFFFF) $display("FAIL cnt_sat got %h exp ffff", underrun_cnt); else pass_cnt++;
    enable = 1'b0;
  endtask
`endif

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_data  = 'x;
    test_reset();
    test_idle_underrun();
    test_ordered_frames();
    test_full();
    test_push_on_load();
    test_mid_reset();
`ifdef TREE_SER_FEEDER_UNDERRUN_CNT_EN
    test_underrun_cnt();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
